// File: rtl/funnel_pkg.sv
// rtl/funnel_pkg.sv - shared constants, types and helpers for the 1:N sample funnel
package funnel_pkg;

  localparam int MAX_LANES = 16;

  typedef logic [MAX_LANES-1:0] lane_mask_t;

  function automatic int lane_ptr_w(input int n);
    return $clog2(n);
  endfunction

  // Mask with the low k lanes set; k is clamped by the mask width.
  function automatic lane_mask_t low_mask(input int k);
    lane_mask_t m;
    for (int i = 0; i < MAX_LANES; i++) begin
      m[i] = (i < k);
    end
    return m;
  endfunction

endpackage

// File: rtl/funnel_lane_ptr.sv
// rtl/funnel_lane_ptr.sv - modulo-N lane pointer with sync load-to-1, clear, last and misalign decode
module funnel_lane_ptr
  import funnel_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int PTR_W     = lane_ptr_w(NUM_LANES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  input  logic             sync_i,
  input  logic             clr_i,
  output logic [PTR_W-1:0] ptr_o,
  output logic             last_o,
  output logic             misalign_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  assign ptr_o      = ptr_q;
  assign last_o     = (ptr_q == PTR_W'(NUM_LANES - 1));
  assign misalign_o = adv_i && sync_i && (ptr_q != '0);

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && sync_i) begin
      // The sync sample itself occupies lane 0, so the next free lane is 1.
      ptr_d = PTR_W'(1);
    end else if (adv_i) begin
      ptr_d = last_o ? '0 : ptr_q + PTR_W'(1);
    end
    if (clr_i) begin
      ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/funnel_1ton.sv
// rtl/funnel_1ton.sv - round-robin 1:N sample funnel with sync alignment; FUNNEL_FLUSH_EN enables partial-group flush
module funnel_1ton
  import funnel_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int NUM_LANES = 2,
  parameter int ERR_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_W-1:0]           din,
  input  logic                        din_valid,
  input  logic                        din_sync,
  input  logic                        flush,
  output logic [NUM_LANES*DATA_W-1:0] dout,
  output logic                        dout_valid,
  output logic [NUM_LANES-1:0]        dout_mask,
  output logic                        misalign,
  output logic [ERR_W-1:0]            err_cnt
);

  localparam int PTR_W = lane_ptr_w(NUM_LANES);

  logic [PTR_W-1:0]            ptr;
  logic                        last;
  logic                        misalign_det;
  logic                        sync_take;
  logic                        complete;
  logic                        flush_emit;
  logic                        emit;
  logic [PTR_W-1:0]            wr_idx;
  lane_mask_t                  fill_mask;
  logic [NUM_LANES*DATA_W-1:0] group_d;

  logic [DATA_W-1:0]           stage_q [NUM_LANES];
  logic [NUM_LANES*DATA_W-1:0] dout_q;
  logic                        dout_valid_q;
  logic [NUM_LANES-1:0]        dout_mask_q;
  logic                        misalign_q;
  logic [ERR_W-1:0]            err_cnt_q;

  assign sync_take = din_valid && din_sync;
  assign complete  = din_valid && !din_sync && last;

`ifdef FUNNEL_FLUSH_EN
  // Flush acts on the pointer after this cycle's sample; a sync or a full group wins.
  assign flush_emit = flush && !sync_take && !complete && (din_valid || (ptr != '0));
`else
  logic flush_unused;
  assign flush_unused = flush;
  assign flush_emit   = 1'b0;
`endif

  assign emit   = complete || flush_emit;
  assign wr_idx = din_sync ? '0 : ptr;

  funnel_lane_ptr #(
    .NUM_LANES (NUM_LANES),
    .PTR_W     (PTR_W)
  ) u_lane_ptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .adv_i      (din_valid),
    .sync_i     (din_sync),
    .clr_i      (flush_emit),
    .ptr_o      (ptr),
    .last_o     (last),
    .misalign_o (misalign_det)
  );

  // Lanes filled so far plus this cycle's sample; for a full group this is all lanes.
  always_comb begin
    int                fill;
    logic [DATA_W-1:0] lane_val;
    fill     = int'(ptr) + (din_valid ? 1 : 0);
    fill_mask = low_mask(fill);
    group_d  = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_val = stage_q[i];
      if (din_valid && !din_sync && (ptr == PTR_W'(i))) begin
        lane_val = din;
      end
      group_d[i*DATA_W +: DATA_W] = fill_mask[i] ? lane_val : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        stage_q[i] <= '0;
      end
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_mask_q  <= '0;
      misalign_q   <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      dout_valid_q <= emit;
      misalign_q   <= misalign_det;
      if (din_valid) begin
        stage_q[wr_idx] <= din;
      end
      if (emit) begin
        dout_q      <= group_d;
        dout_mask_q <= fill_mask[NUM_LANES-1:0];
      end
      if (misalign_det && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + ERR_W'(1);
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign dout_mask  = dout_mask_q;
  assign misalign   = misalign_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_funnel_1ton.sv
// tb/tb_funnel_1ton.sv - directed table-driven bench for funnel_1ton (4 lanes, 2-bit error counter)
module tb_funnel_1ton;

  localparam int DW = 16;
  localparam int NL = 4;
  localparam int EW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [DW-1:0]  din;
  logic           din_valid;
  logic           din_sync;
  logic           flush;
  logic [NL*DW-1:0] dout;
  logic           dout_valid;
  logic [NL-1:0]  dout_mask;
  logic           misalign;
  logic [EW-1:0]  err_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         v;
    logic         s;
    logic [15:0]  d;
    logic         ev;
    logic [63:0]  edout;
    logic [3:0]   emask;
    logic         emis;
    logic [1:0]   eerr;
  } vec_t;

  vec_t vecs[$];

  funnel_1ton #(.DATA_W(DW), .NUM_LANES(NL), .ERR_W(EW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_sync   (din_sync),
    .flush      (flush),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_mask  (dout_mask),
    .misalign   (misalign),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] g(input logic [15:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic f, input logic [15:0] d);
    @(negedge clk);
    din_valid = v;
    din_sync  = s;
    flush     = f;
    din       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, s, input logic [15:0] d, input logic ev,
                     input logic [63:0] edout, input logic [3:0] emask,
                     input logic emis, input logic [1:0] eerr);
    vec_t r;
    r.v = v; r.s = s; r.d = d; r.ev = ev; r.edout = edout;
    r.emask = emask; r.emis = emis; r.eerr = eerr;
    vecs.push_back(r);
  endtask

  initial begin
    logic [63:0] G1, G2, G3, G4, G5;
    G1 = g(16'd1, 16'd2, 16'd3, 16'd4);
    G2 = g(16'd5, 16'd6, 16'd7, 16'd8);
    G3 = g(16'h00C0, 16'h00D0, 16'h00E0, 16'h00F0);
    G4 = g(16'h0100, 16'h0101, 16'h0102, 16'h0103);
    G5 = g(16'h0011, 16'h0012, 16'h0013, 16'h0014);

    // continuous 1..8
    add(1, 0, 16'd1, 0, 64'd0, 4'h0, 0, 0);
    add(1, 0, 16'd2, 0, 64'd0, 4'h0, 0, 0);
    add(1, 0, 16'd3, 0, 64'd0, 4'h0, 0, 0);
    add(1, 0, 16'd4, 1, G1, 4'hF, 0, 0);
    add(1, 0, 16'd5, 0, G1, 4'hF, 0, 0);
    add(1, 0, 16'd6, 0, G1, 4'hF, 0, 0);
    add(1, 0, 16'd7, 0, G1, 4'hF, 0, 0);
    add(1, 0, 16'd8, 1, G2, 4'hF, 0, 0);
    // same samples with idle gaps
    add(1, 0, 16'd1, 0, G2, 4'hF, 0, 0);
    add(0, 0, 16'hDEAD, 0, G2, 4'hF, 0, 0);
    add(1, 0, 16'd2, 0, G2, 4'hF, 0, 0);
    add(0, 0, 16'hDEAD, 0, G2, 4'hF, 0, 0);
    add(1, 0, 16'd3, 0, G2, 4'hF, 0, 0);
    add(0, 0, 16'hDEAD, 0, G2, 4'hF, 0, 0);
    add(1, 0, 16'd4, 1, G1, 4'hF, 0, 0);
    add(0, 0, 16'hDEAD, 0, G1, 4'hF, 0, 0);
    add(1, 0, 16'd5, 0, G1, 4'hF, 0, 0);
    add(0, 0, 16'hDEAD, 0, G1, 4'hF, 0, 0);
    add(1, 0, 16'd6, 0, G1, 4'hF, 0, 0);
    add(0, 0, 16'hDEAD, 0, G1, 4'hF, 0, 0);
    add(1, 0, 16'd7, 0, G1, 4'hF, 0, 0);
    add(0, 0, 16'hDEAD, 0, G1, 4'hF, 0, 0);
    add(1, 0, 16'd8, 1, G2, 4'hF, 0, 0);
    // sync without valid, then misaligned sync
    add(0, 1, 16'hDEAD, 0, G2, 4'hF, 0, 0);
    add(1, 1, 16'h00A0, 0, G2, 4'hF, 0, 0);
    add(1, 0, 16'h00B0, 0, G2, 4'hF, 0, 0);
    add(1, 1, 16'h00C0, 0, G2, 4'hF, 1, 1);
    add(1, 0, 16'h00D0, 0, G2, 4'hF, 0, 1);
    add(1, 0, 16'h00E0, 0, G2, 4'hF, 0, 1);
    add(1, 0, 16'h00F0, 1, G3, 4'hF, 0, 1);
    // aligned sync at lane 0 raises no error
    add(1, 1, 16'h0100, 0, G3, 4'hF, 0, 1);
    add(1, 0, 16'h0101, 0, G3, 4'hF, 0, 1);
    add(1, 0, 16'h0102, 0, G3, 4'hF, 0, 1);
    add(1, 0, 16'h0103, 1, G4, 4'hF, 0, 1);

    rst_n = 1'b0; din = '0; din_valid = 1'b0; din_sync = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout", dout, 64'd0);
    check("rst_valid", {63'd0, dout_valid}, 64'd0);
    check("rst_mask", {60'd0, dout_mask}, 64'd0);
    check("rst_mis", {63'd0, misalign}, 64'd0);
    check("rst_err", {62'd0, err_cnt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].s, 1'b0, vecs[i].d);
      check($sformatf("v%0d_valid", i), {63'd0, dout_valid}, {63'd0, vecs[i].ev});
      check($sformatf("v%0d_dout", i), dout, vecs[i].edout);
      check($sformatf("v%0d_mask", i), {60'd0, dout_mask}, {60'd0, vecs[i].emask});
      check($sformatf("v%0d_mis", i), {63'd0, misalign}, {63'd0, vecs[i].emis});
      check($sformatf("v%0d_err", i), {62'd0, err_cnt}, {62'd0, vecs[i].eerr});
    end

    // saturation: aligned sync, then four back-to-back misaligned syncs
    step(1, 1, 0, 16'h0200);
    check("sat0_mis", {63'd0, misalign}, 64'd0);
    check("sat0_err", {62'd0, err_cnt}, 64'd1);
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 0, 16'h0201);
      check($sformatf("sat%0d_mis", k + 1), {63'd0, misalign}, 64'd1);
      check($sformatf("sat%0d_err", k + 1), {62'd0, err_cnt}, (k == 0) ? 64'd2 : 64'd3);
      check($sformatf("sat%0d_valid", k + 1), {63'd0, dout_valid}, 64'd0);
    end
    step(0, 0, 0, 16'h0);
    check("sat_mis_drop", {63'd0, misalign}, 64'd0);
    check("sat_hold", {62'd0, err_cnt}, 64'd3);

    // reset mid-group discards the partial group
    step(0, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0021);
    step(1, 0, 0, 16'h0022);
    check("pre_rst_valid", {63'd0, dout_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b0;
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_dout", dout, 64'd0);
    check("mid_rst_err", {62'd0, err_cnt}, 64'd0);
    check("mid_rst_valid", {63'd0, dout_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 16'h0011 + 16'(k));
      check($sformatf("post_rst%0d_valid", k), {63'd0, dout_valid}, (k == 3) ? 64'd1 : 64'd0);
    end
    check("post_rst_dout", dout, G5);
    check("post_rst_mask", {60'd0, dout_mask}, 64'hF);
    step(0, 0, 0, 16'h0);
    check("post_rst_strobe_drop", {63'd0, dout_valid}, 64'd0);

    // flush of a two-sample partial group
    step(1, 0, 0, 16'd9);
    step(1, 0, 0, 16'd10);
    check("fl_pre_valid", {63'd0, dout_valid}, 64'd0);
    step(0, 0, 1, 16'h0);
`ifdef FUNNEL_FLUSH_EN
    check("fl_valid", {63'd0, dout_valid}, 64'd1);
    check("fl_dout", dout, g(16'd9, 16'd10, 16'd0, 16'd0));
    check("fl_mask", {60'd0, dout_mask}, 64'h3);
    step(0, 0, 1, 16'h0);
    check("fl_empty_valid", {63'd0, dout_valid}, 64'd0);
    // flush coinciding with a full group gives one normal strobe
    step(1, 0, 0, 16'd1);
    step(1, 0, 0, 16'd2);
    step(1, 0, 0, 16'd3);
    step(1, 0, 1, 16'd4);
    check("fl_full_valid", {63'd0, dout_valid}, 64'd1);
    check("fl_full_dout", dout, G1);
    check("fl_full_mask", {60'd0, dout_mask}, 64'hF);
    step(0, 0, 1, 16'h0);
    check("fl_full_no_extra", {63'd0, dout_valid}, 64'd0);
`else
    check("fl_valid", {63'd0, dout_valid}, 64'd0);
    check("fl_dout", dout, G5);
    check("fl_mask", {60'd0, dout_mask}, 64'hF);
    step(0, 0, 1, 16'h0);
    check("fl_again_valid", {63'd0, dout_valid}, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/funnel_1ton.md
Name: funnel_1ton

Overview:
Parametrised successor of the 1-to-2 funnel. Takes one DATA_W-bit sample stream at full DSP rate (200 MHz, source-synchronous clk) and distributes consecutive valid samples round-robin across NUM_LANES lanes. Each completed group is presented atomically on a wide parallel output with a one-cycle strobe, so downstream logic can run at 1/NUM_LANES throughput. Adds frame alignment via a sync marker, misalignment detection and an error counter.

Parameters:
DATA_W, 16, sample width in bits
NUM_LANES, 2, lanes per group; legal range 2..16, power of two not required
ERR_W, 8, width of saturating misalignment counter

Ports:
clk  in  1  single clock, 200 MHz, source-synchronous with DSP
rst_n  in  1  synchronous reset, active-low
din  in  DATA_W  input sample
din_valid  in  1  din qualifier
din_sync  in  1  marks din as lane 0 of a new group; ignored unless din_valid=1
flush  in  1  emit partial group; functional only with FUNNEL_FLUSH_EN
dout  out  NUM_LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
dout_valid  out  1  one-cycle strobe, dout holds a new group
dout_mask  out  NUM_LANES  bit i = lane i holds real data
misalign  out  1  one-cycle pulse, sync arrived mid-group
err_cnt  out  ERR_W  saturating count of misalign events

Behaviour:
- Reset (rst_n=0 at posedge clk): lane pointer=0, staging cleared, dout=0, dout_valid=0, dout_mask=0, misalign=0, err_cnt=0. Reset mid-group discards the partial group; no strobe is issued.
- Lane pointer ptr, width $clog2(NUM_LANES), advances only on din_valid.
- din_valid=1, din_sync=0: stage[ptr]<=din. If ptr==NUM_LANES-1, ptr<=0; otherwise ptr<=ptr+1.
- Group completion (din_valid with ptr==NUM_LANES-1): on the next edge dout<={din, stage[NUM_LANES-2:0]}, dout_mask<=all ones, dout_valid<=1 for exactly one cycle. Latency: last sample is visible on dout one cycle after its capture edge.
- dout and dout_mask hold their value until the next group is emitted. dout_valid=0 on every cycle that does not complete a group.
- din_valid=1, din_sync=1: din goes to lane 0 and ptr<=1. If ptr!=0 at that time, the partial group is discarded without emission, misalign pulses for one cycle, and err_cnt increments, saturating at all ones. If ptr==0, there is no error.
- din_sync=1 with din_valid=0: no effect.
- No back-pressure; output consumer must accept every strobe. Gaps in din_valid are allowed and only stall ptr.
- NUM_LANES==2 with din_sync never asserted is cycle-equivalent to the legacy 1:2 funnel, plus the strobe.

Optional Feature:
FUNNEL_FLUSH_EN
- Defined: flush=1 with ptr!=0 (ptr evaluated after any same-cycle din_valid sample is taken in) emits the partial group on the next edge:
  - dout_valid=1.
  - dout_mask has the low k bits set, where k = lanes filled.
  - Unfilled lanes drive zero.
  - ptr<=0.
- flush with ptr==0 after the update: no effect.
- flush together with completion of a full group: the normal full emit occurs, no extra strobe.
- din_sync has priority over flush.
- Not defined: flush is ignored, and dout_mask is always all ones whenever dout_valid is asserted.

Decomposition:
- Package funnel_pkg holds:
  - MAX_LANES=16.
  - Function lane_ptr_w(n) returning $clog2(n).
  - Typedef lane_mask_t.
- One sub-module, funnel_lane_ptr: the modulo-NUM_LANES pointer with sync-load-to-1, clear, and "last" / "misalign" decode.
- Staging, output registers and err_cnt stay in the top module.

Test Plan:
- NUM_LANES=4, din_valid continuous with din=1,2,3,4,5,6,7,8 -> two strobes; dout={4,3,2,1} and then {8,7,6,5}; each strobe one cycle after its 4th sample.
- Same stimulus with din_valid low every other cycle -> same two groups, strobes delayed accordingly, dout stable between strobes.
- din=A,B with sync on A, then C with sync -> misalign pulse, err_cnt=1, no strobe for {A,B}; C becomes lane 0 of the next group.
- ERR_W=2, 5 misalignments -> err_cnt sticks at 3.
- rst_n low after 2 of 4 samples, then 4 samples -> no strobe from the partial group; next group aligned at lane 0.
- FUNNEL_FLUSH_EN, NUM_LANES=4: samples 9,10 then flush -> dout={0,0,10,9}, dout_mask=4'b0011, dout_valid=1. Without the macro the same stimulus gives no strobe.
